// File: rtl/arith_pkg.sv
// Shared arithmetic types for the shift-add multiplier datapath.
//   mul_state_t : multiplier control FSM states
//   cnt_w(n)    : width of a counter that must hold values 0..n
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder, purely combinational.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin (low N bits)
//   cout : carry out of the top bit
module ripple_carry_adder #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  // Carry ripples bit by bit through a block-local variable.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier, one add-and-shift step per clock,
// built around a single N-bit ripple-carry adder.
// Optional feature macro: ZERO_BYPASS_EN (zero operand skips straight to DONE).
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : operands valid          in_ready  : high only in IDLE
//   multiplicand : operand A (N bits)      multiplier: operand B (N bits)
//   out_valid    : high only in DONE       out_ready : consumer accepts product
//   product      : A*B (2N bits), stable while out_valid
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = cnt_w(N);

  mul_state_t    state, state_d;
  logic [N-1:0]  acc, acc_d;
  logic [N-1:0]  q, q_d;
  logic [N-1:0]  areg, areg_d;
  logic [CW-1:0] count, count_d;

  logic [N-1:0]  add_sum;
  logic          add_cout;

  // Single adder: acc + Areg, carry captured as the new top bit.
  ripple_carry_adder #(.N(N)) u_add (
    .a    (acc),
    .b    (areg),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    q_d     = q;
    areg_d  = areg;
    count_d = count;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          areg_d  = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          count_d = '0;
`ifdef ZERO_BYPASS_EN
          if ((multiplicand == '0) || (multiplier == '0)) begin
            q_d     = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end
      RUN: begin
        if (q[0]) begin
          {acc_d, q_d} = {add_cout, add_sum, q[N-1:1]};
        end else begin
          {acc_d, q_d} = {1'b0, acc, q[N-1:1]};
        end
        count_d = count + CW'(1);
        if (count == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      areg      <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      q         <= q_d;
      areg      <= areg_d;
      count     <= count_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (state_d == DONE) begin
        product <= {acc_d, q_d};
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (N=4), scoreboard based.
module tb_shift_add_multiplier;

  localparam int unsigned N = 4;
`ifdef ZERO_BYPASS_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   multiplicand;
  logic [3:0]   multiplier;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   product;

  logic [7:0]   exp_q[$];
  int           passed = 0;
  int           total  = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'd0) begin
      $display("FAIL reset_outputs: got rdy=%b vld=%b prod=%0d expected 1 0 0",
               in_ready, out_valid, product);
    end else passed++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL idle_after_reset: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end else passed++;
  endtask

  // One transaction; in_valid is held with junk operands while busy to show it is ignored.
  task automatic test_mul(input string name, input logic [3:0] a, input logic [3:0] b,
                          input int exp_lat);
    int lat;
    int guard;
    bit rdy_seen;
    logic [7:0] exp;
    @(negedge clk);
    multiplicand = a; multiplier = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    exp_q.push_back({4'b0, a} * {4'b0, b});
    @(negedge clk);
    multiplicand = 4'($urandom); multiplier = 4'($urandom);
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk); lat++;
    end
    in_valid = 1'b0;
    total++;
    if (lat !== exp_lat) begin
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end else passed++;
    total++;
    if (rdy_seen || in_ready !== 1'b0) begin
      $display("FAIL %s_in_ready_busy: got seen=%b now=%b expected 0 0", name, rdy_seen, in_ready);
    end else passed++;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    out_ready = 1'b1;
    total++;
    if (product !== exp) begin
      $display("FAIL %s_product: got %0d expected %0d", name, product, exp);
    end else passed++;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
      $display("FAIL %s_return_idle: got rdy=%b vld=%b q=%0d expected 1 0 0",
               name, in_ready, out_valid, exp_q.size());
    end else passed++;
  endtask

  task automatic test_stall();
    int guard;
    bit bad;
    logic [7:0] exp;
    @(negedge clk);
    multiplicand = 4'd7; multiplier = 4'd6; in_valid = 1'b1;
    exp_q.push_back(8'd42);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin @(negedge clk); guard++; end
    exp = exp_q.pop_front();
    bad = 1'b0;
    repeat (5) begin
      if (product !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    total++;
    if (bad || product !== exp) begin
      $display("FAIL stall_hold: got prod=%0d vld=%b rdy=%b expected %0d 1 0",
               product, out_valid, in_ready, exp);
    end else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL stall_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end else passed++;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    multiplicand = 4'd9; multiplier = 4'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'd0) begin
      $display("FAIL reset_mid_run: got rdy=%b vld=%b prod=%0d expected 1 0 0",
               in_ready, out_valid, product);
    end else passed++;
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    test_mul("after_reset", 4'd3, 4'd5, 4);
  endtask

  task automatic test_back_to_back();
    int got;
    int bad;
    fork
      begin : producer
        int guard;
        for (int i = 0; i < 256; i++) begin
          in_valid = 1'b0;
          while ($urandom_range(0, 3) == 0) @(negedge clk);
          multiplicand = 4'(i >> 4); multiplier = 4'(i);
          in_valid = 1'b1;
          guard = 0;
          while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
          exp_q.push_back({4'b0, multiplicand} * {4'b0, multiplier});
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int cyc;
        logic [7:0] exp;
        got = 0; bad = 0; cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(negedge clk); cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            total++;
            if (product !== exp) begin
              $display("FAIL b2b_product: got %0d expected %0d", product, exp);
              bad++;
            end else passed++;
            got++;
          end
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    out_ready = 1'b0;
    total++;
    if (got != 256 || exp_q.size() != 0) begin
      $display("FAIL b2b_transfer_count: got %0d left %0d expected 256 0", got, exp_q.size());
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_mul("a13_b11", 4'd13, 4'd11, 4);
    test_mul("a15_b15", 4'd15, 4'd15, 4);
    test_mul("a0_b9",   4'd0,  4'd9,  ZLAT);
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
